// File: rtl/pitch_smoother.sv
// Pitch conditioning for the pixel filter: clamps raw pitch samples, keeps a power-of-two
// moving average and injects zero samples after long silences so the output decays to 0.
module pitch_smoother #(
    parameter int LOG2_DEPTH  = 3,
    parameter int MAX_PITCH   = 1023,
    parameter int HOLD_CYCLES = 12_500_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pitch_valid,
    input  logic [29:0] pitch_in,
    output logic        pitch_ready,
    output logic [29:0] pitch_output,
    output logic        pitch_output_valid
);

    localparam int IN_W     = 30;
    localparam int SAMPLE_W = $clog2(MAX_PITCH + 1);
    localparam int SUM_W    = SAMPLE_W + LOG2_DEPTH;
    localparam int DEPTH    = 2 ** LOG2_DEPTH;
    localparam int CNT_W    = $clog2(HOLD_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

    state_t                  state_r;
    logic                    ready_r;
    logic                    out_valid_r;
    logic [IN_W-1:0]         out_r;
    logic [SAMPLE_W-1:0]     sample_r;
    logic [SAMPLE_W-1:0]     win_r [DEPTH];
    logic [SUM_W-1:0]        sum_r;
    logic [LOG2_DEPTH-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]        idle_cnt_r;
    logic [SAMPLE_W-1:0]     clamp_s;
    logic                    accept_s;

    assign accept_s           = pitch_valid & ready_r;
    assign pitch_ready        = ready_r;
    assign pitch_output       = out_r;
    assign pitch_output_valid = out_valid_r;

    // Saturate the raw estimate to the sample range held in the window.
    always_comb begin
        if (pitch_in > IN_W'(MAX_PITCH)) begin
            clamp_s = SAMPLE_W'(MAX_PITCH);
        end else begin
            clamp_s = pitch_in[SAMPLE_W-1:0];
        end
    end

    // Sample / decay sequencing, running sum over the window and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            ready_r     <= 1'b0;
            out_valid_r <= 1'b0;
            out_r       <= '0;
            sample_r    <= '0;
            sum_r       <= '0;
            wr_ptr_r    <= '0;
            idle_cnt_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                win_r[i] <= '0;
            end
        end else begin
            out_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // A real sample arriving on the decay cycle takes priority.
                    if (accept_s) begin
                        sample_r   <= clamp_s;
                        idle_cnt_r <= '0;
                        ready_r    <= 1'b0;
                        state_r    <= ST_ACCUM;
                    end else if (idle_cnt_r == CNT_W'(HOLD_CYCLES - 1)) begin
                        sample_r   <= '0;
                        idle_cnt_r <= '0;
                        ready_r    <= 1'b0;
                        state_r    <= ST_ACCUM;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + CNT_W'(1);
                        ready_r    <= 1'b1;
                        state_r    <= ST_IDLE;
                    end
                end
                ST_ACCUM: begin
                    sum_r           <= sum_r - SUM_W'(win_r[wr_ptr_r]) + SUM_W'(sample_r);
                    win_r[wr_ptr_r] <= sample_r;
                    wr_ptr_r        <= wr_ptr_r + LOG2_DEPTH'(1);
                    ready_r         <= 1'b0;
                    state_r         <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    out_r       <= IN_W'(sum_r >> LOG2_DEPTH);
                    out_valid_r <= 1'b1;
                    ready_r     <= 1'b1;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    ready_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pitch_smoother.sv
// Directed bench for pitch_smoother with a 16-cycle hold window.
module tb_pitch_smoother;

    logic        clk;
    logic        rst_n;
    logic        pitch_valid;
    logic [29:0] pitch_in;
    logic        pitch_ready;
    logic [29:0] pitch_output;
    logic        pitch_output_valid;

    int checks   = 0;
    int failures = 0;

    pitch_smoother #(.HOLD_CYCLES(16)) dut (
        .clk                (clk),
        .reset_n            (rst_n),
        .pitch_valid        (pitch_valid),
        .pitch_in           (pitch_in),
        .pitch_ready        (pitch_ready),
        .pitch_output       (pitch_output),
        .pitch_output_valid (pitch_output_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at a negedge with the block back in IDLE.
    task automatic send_check(input string tag, input logic [29:0] val, input logic [31:0] exp);
        int waited;
        waited = 0;
        while (!pitch_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_eq({tag, "_ready_wait"}, 32'(pitch_ready), 32'd1);
        pitch_valid = 1'b1;
        pitch_in    = val;
        @(negedge clk);
        pitch_valid = 1'b0;
        pitch_in    = 30'd0;
        check_eq({tag, "_ready_accum"}, 32'(pitch_ready), 32'd0);
        check_eq({tag, "_valid_accum"}, 32'(pitch_output_valid), 32'd0);
        @(negedge clk);
        check_eq({tag, "_ready_output"}, 32'(pitch_ready), 32'd0);
        check_eq({tag, "_valid_output"}, 32'(pitch_output_valid), 32'd0);
        @(negedge clk);
        check_eq({tag, "_valid"}, 32'(pitch_output_valid), 32'd1);
        check_eq({tag, "_out"}, pitch_output, exp);
        check_eq({tag, "_ready_back"}, 32'(pitch_ready), 32'd1);
    endtask

    // Silence until the next valid pulse; a decay takes 16 idle edges plus 2 pipeline edges.
    task automatic decay_check(input string tag, input logic [31:0] exp);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pitch_output_valid && n < 40);
        check_eq({tag, "_cycles"}, 32'(n), 32'd18);
        check_eq({tag, "_out"}, pitch_output, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("rst_ready", 32'(pitch_ready), 32'd0);
        check_eq("rst_out", pitch_output, 32'd0);
        check_eq("rst_valid", 32'(pitch_output_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("rst_ready_pre_edge", 32'(pitch_ready), 32'd0);
        @(negedge clk);
        check_eq("rst_ready_post_edge", 32'(pitch_ready), 32'd1);
    endtask

    initial begin
        rst_n       = 1'b0;
        pitch_valid = 1'b0;
        pitch_in    = 30'd0;
        @(negedge clk);

        // Reset then clamp
        do_reset();
        send_check("clamp_5000", 30'd5000, 32'd127);
        send_check("clamp_1023", 30'd1023, 32'd255);

        // Fill then wrap
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send_check($sformatf("fill%0d", i), 30'd40, 32'(5 * (i + 1)));
        end
        for (int i = 0; i < 8; i++) begin
            send_check($sformatf("wrap%0d", i), 30'd80, 32'(40 + 5 * (i + 1)));
        end

        // Decay from a window full of 40
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send_check($sformatf("dfill%0d", i), 30'd40, 32'(5 * (i + 1)));
        end
        for (int i = 0; i < 8; i++) begin
            decay_check($sformatf("decay%0d", i), 32'(35 - 5 * i));
        end
        decay_check("decay_hold0", 32'd0);

        // Sample arriving on the counter==15 cycle wins over decay
        repeat (15) @(negedge clk);
        send_check("decay_race", 30'd40, 32'd5);

        // Reset while in ACCUM
        pitch_valid = 1'b1;
        pitch_in    = 30'd80;
        @(negedge clk);
        pitch_valid = 1'b0;
        check_eq("midrst_in_accum", 32'(pitch_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out", pitch_output, 32'd0);
        check_eq("midrst_valid", 32'(pitch_output_valid), 32'd0);
        check_eq("midrst_ready", 32'(pitch_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_check("midrst_after", 30'd40, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
